vme_cmd_arbiter: RTL and testbench
==================================

VME_CMD_ARBITER -- requirements
Module: vme_cmd_arbiter

Interface
REQ-001 Parameter MASK, default 32'h00A80000: constant ORed into every issued vme_cmd_reg and driven as the idle value.
REQ-002 Parameter TO_CYCLES, default 1023: number of WAIT cycles without completion before timeout.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Ports req0/req1, input, 1 each: level request from requester 0 (host) and requester 1 (monitor poller).
REQ-006 Ports rw0/rw1, input, 1 each: 1 = read, 0 = write.
REQ-007 Ports cmd0/cmd1, input, 16 each: VME instruction.
REQ-008 Ports wdat0/wdat1, input, 16 each: write data.
REQ-009 Ports ack0/ack1, output, 1 each: one-cycle pulse when the request is latched.
REQ-010 Ports done0/done1, output, 1 each: one-cycle pulse when the transaction ends.
REQ-011 Ports err0/err1, output, 1 each: timeout flag, valid with done.
REQ-012 Ports rdata0/rdata1, output, 16 each: read data, valid from done onward.
REQ-013 Port vme_cmd_rd, input, 1: VME engine ready for a command.
REQ-014 Port vme_dat_wr, input, 1: VME engine completion strobe.
REQ-015 Port vme_dat_reg_out, input, 32: VME engine return data.
REQ-016 Port start, output, 1: command-issue strobe.
REQ-017 Port vme_cmd_reg, output, 32: command word.
REQ-018 Port vme_dat_reg_in, output, 32: write data, zero-extended.
REQ-019 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT; all outputs registered.
REQ-021 IDLE->ISSUE when vme_cmd_rd=1 and any req is high.
- Latch the winner's rw/cmd/wdat and pulse its ack in the ISSUE cycle.
- While vme_cmd_rd=0, the FSM stays in IDLE regardless of req.
REQ-022 Arbitration is round-robin.
- If both requesters are high, grant the one not granted last.
- The last-grant pointer resets to 1, so requester 0 wins the first tie.
- A single requester is always granted.
REQ-023 ISSUE lasts exactly one cycle, with:
- start=1;
- vme_cmd_reg = MASK | {16'b0, cmd};
- bit 25 set for a read, or bit 24 set for a write;
- vme_dat_reg_in = {16'b0, wdat} for a write, or 0 for a read.
Then ISSUE->WAIT, with the timeout counter cleared.
REQ-024 WAIT: start=0; vme_cmd_reg and vme_dat_reg_in hold their ISSUE values; the 10-bit counter increments each cycle.
REQ-025 WAIT, vme_dat_wr=1:
- The next cycle pulses done (err=0) for the granted requester.
- For a read, rdata takes vme_dat_reg_out[15:0]; for a write, rdata is unchanged.
- WAIT->IDLE.
REQ-026 WAIT, counter reaching TO_CYCLES without vme_dat_wr:
- done and err pulse for the granted requester, with rdata unchanged.
- WAIT->IDLE.
REQ-027 vme_dat_wr and timeout in the same cycle: completion wins, err=0.
REQ-028 vme_dat_wr in IDLE or ISSUE is ignored.
REQ-029 The ungranted requester's outputs stay unchanged throughout a transaction.
REQ-030 On every return to IDLE, vme_cmd_reg=MASK and vme_dat_reg_in=0.
REQ-031 Re-grant is possible at the first edge in IDLE; the minimum transaction is 4 cycles from request sample to next grant sample.
REQ-032 A requester that holds req after done is re-served only when round-robin permits.

Reset
REQ-033 While rst=1:
- state=IDLE, start=0, vme_cmd_reg=MASK, vme_dat_reg_in=0;
- ack/done/err=0, rdata0/rdata1=0, busy=0;
- counter=0, last-grant pointer=1.
REQ-034 Reset mid-transaction aborts it: no done pulse and no err is issued.
REQ-035 After rst deasserts, the first grant happens no earlier than the first rising edge with rst=0.

Verification
REQ-036 Read, requester 0:
- Stimulus: req0=1, rw0=1, cmd0=16'h4100, vme_cmd_rd=1; then vme_dat_wr=1 with vme_dat_reg_out=32'h0000BEEF.
- Response: one-cycle start with vme_cmd_reg=32'h02A84100, vme_dat_reg_in=0; then done0=1, err0=0, rdata0=16'hBEEF.
REQ-037 Write, requester 1:
- Stimulus: rw1=0, cmd1=16'h7000, wdat1=16'h00FF.
- Response: vme_cmd_reg=32'h01A87000, vme_dat_reg_in=32'h000000FF; rdata1 unchanged after done1.
REQ-038 Both requesters held high for 4 transactions: grant order 0,1,0,1; each ack is exactly one cycle.
REQ-039 Timeout:
- Stimulus: no vme_dat_wr after start.
- Response: done=1 and err=1 exactly 1023 WAIT cycles later; busy then low; vme_cmd_reg=32'h00A80000.
REQ-040 Simultaneous completion:
- Stimulus: vme_dat_wr=1 on the timeout cycle.
- Response: err=0 and rdata captured.
REQ-041 Gating and reset:
- vme_cmd_rd=0 with req0=1: no start.
- rst pulsed during WAIT: all outputs return to their reset values, with no done pulse.

Source files
------------

// File: rtl/vme_cmd_arbiter_if.sv
// vme_cmd_arbiter_if
//   Bundles the two requester channels and the VME engine command/data
//   channel that the arbiter sits between.
//   Requester side : req0/1, rw0/1, cmd0/1, wdat0/1 in; ack0/1, done0/1,
//                    err0/1, rdata0/1 out.
//   Engine side    : vme_cmd_rd, vme_dat_wr, vme_dat_reg_out in; start,
//                    vme_cmd_reg, vme_dat_reg_in out.
//   Status         : busy out.
//   Modport slave is the arbiter; modport master is whatever drives it.
interface vme_cmd_arbiter_if;
    logic        req0;
    logic        req1;
    logic        rw0;
    logic        rw1;
    logic [15:0] cmd0;
    logic [15:0] cmd1;
    logic [15:0] wdat0;
    logic [15:0] wdat1;
    logic        ack0;
    logic        ack1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        busy;

    modport slave (
        input  req0, req1, rw0, rw1, cmd0, cmd1, wdat0, wdat1,
        input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
        output ack0, ack1, done0, done1, err0, err1, rdata0, rdata1,
        output start, vme_cmd_reg, vme_dat_reg_in, busy
    );

    modport master (
        output req0, req1, rw0, rw1, cmd0, cmd1, wdat0, wdat1,
        output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
        input  ack0, ack1, done0, done1, err0, err1, rdata0, rdata1,
        input  start, vme_cmd_reg, vme_dat_reg_in, busy
    );
endinterface

// File: rtl/vme_cmd_arbiter.sv
// vme_cmd_arbiter
//   Round-robin arbiter sharing one VME command engine between the host
//   (requester 0) and the monitor poller (requester 1). A granted request
//   is issued as a one-cycle start strobe with the command word, then the
//   arbiter waits for the engine's completion strobe or a timeout and
//   reports done/err (and read data) back to the granted requester.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : vme_cmd_arbiter_if.slave (requester and engine channels)
//   Parameters:
//     MASK      : constant ORed into every command word; idle command value
//     TO_CYCLES : WAIT cycles without completion before timeout (<= 1024)
//   All outputs are registered.
module vme_cmd_arbiter #(
    parameter logic [31:0] MASK      = 32'h00A8_0000,
    parameter int unsigned TO_CYCLES = 1023
) (
    input logic               clk,
    input logic               rst,
    vme_cmd_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [31:0] RD_BIT  = 32'h0200_0000;
    localparam logic [31:0] WR_BIT  = 32'h0100_0000;
    // Counter value during the last WAIT cycle before the timeout fires.
    localparam logic [9:0]  TO_LAST = 10'(TO_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;       // last granted requester
    logic        gnt_q, gnt_d;         // requester owning the current transaction
    logic        rd_q, rd_d;           // current transaction is a read
    logic [9:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic [31:0] cmd_reg_q, cmd_reg_d;
    logic [31:0] dat_in_q, dat_in_d;
    logic        busy_q, busy_d;

    logic        sel1;
    logic        w_rw;
    logic [15:0] w_cmd;
    logic [15:0] w_wdat;
    logic [15:0] unused_dat_hi;

    // Only the low half of the engine return word is ever delivered.
    assign unused_dat_hi = bus.vme_dat_reg_out[31:16];

    // Requester 1 wins when it is alone, or on a tie when requester 0 was last.
    always_comb begin
        sel1   = bus.req1 && (!bus.req0 || !last_q);
        w_rw   = sel1 ? bus.rw1   : bus.rw0;
        w_cmd  = sel1 ? bus.cmd1  : bus.cmd0;
        w_wdat = sel1 ? bus.wdat1 : bus.wdat0;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        ack_d     = '0;
        done_d    = '0;
        err_d     = '0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        cmd_reg_d = cmd_reg_q;
        dat_in_d  = dat_in_q;

        unique case (state_q)
            IDLE: begin
                if (bus.vme_cmd_rd && (bus.req0 || bus.req1)) begin
                    state_d   = ISSUE;
                    gnt_d     = sel1;
                    last_d    = sel1;
                    rd_d      = w_rw;
                    start_d   = 1'b1;
                    ack_d     = sel1 ? 2'b10 : 2'b01;
                    cmd_reg_d = MASK | {16'h0000, w_cmd} | (w_rw ? RD_BIT : WR_BIT);
                    dat_in_d  = w_rw ? '0 : {16'h0000, w_wdat};
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 10'd1;
                // Completion takes priority over a timeout in the same cycle.
                if (bus.vme_dat_wr || (cnt_q == TO_LAST)) begin
                    state_d   = IDLE;
                    cmd_reg_d = MASK;
                    dat_in_d  = '0;
                    done_d    = gnt_q ? 2'b10 : 2'b01;
                    if (!bus.vme_dat_wr) begin
                        err_d = done_d;
                    end else if (rd_q) begin
                        if (gnt_q) rdata1_d = bus.vme_dat_reg_out[15:0];
                        else       rdata0_d = bus.vme_dat_reg_out[15:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            cmd_reg_q <= MASK;
            dat_in_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            cmd_reg_q <= cmd_reg_d;
            dat_in_q  <= dat_in_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ack0           = ack_q[0];
    assign bus.ack1           = ack_q[1];
    assign bus.done0          = done_q[0];
    assign bus.done1          = done_q[1];
    assign bus.err0           = err_q[0];
    assign bus.err1           = err_q[1];
    assign bus.rdata0         = rdata0_q;
    assign bus.rdata1         = rdata1_q;
    assign bus.start          = start_q;
    assign bus.vme_cmd_reg    = cmd_reg_q;
    assign bus.vme_dat_reg_in = dat_in_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// tb_vme_cmd_arbiter
//   Drives vme_cmd_arbiter through directed and randomized transactions and
//   compares every response with a transaction-level model (round-robin
//   pointer, command word arithmetic, per-requester read data).
module tb_vme_cmd_arbiter;

    localparam logic [31:0] MASK = 32'h00A8_0000;
    localparam int          TO   = 1023;

    logic clk = 1'b0;
    logic rst;

    vme_cmd_arbiter_if bus ();

    vme_cmd_arbiter #(
        .MASK      (MASK),
        .TO_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          last_gnt = 1;
    logic [15:0] m_rdata [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cmd(input logic rw, input logic [15:0] c);
        return MASK | {16'h0000, c} | (rw ? 32'h0200_0000 : 32'h0100_0000);
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, ".start"}, bus.start, 1'b0);
        check_eq({tag, ".ack"},   {bus.ack0, bus.ack1}, 2'b00);
        check_eq({tag, ".done"},  {bus.done0, bus.done1}, 2'b00);
        check_eq({tag, ".err"},   {bus.err0, bus.err1}, 2'b00);
        check_eq({tag, ".busy"},  bus.busy, 1'b0);
        check_eq({tag, ".cmd"},   bus.vme_cmd_reg, MASK);
        check_eq({tag, ".dat"},   bus.vme_dat_reg_in, 32'h0);
        check_eq({tag, ".rdata0"}, bus.rdata0, m_rdata[0]);
        check_eq({tag, ".rdata1"}, bus.rdata1, m_rdata[1]);
    endtask

    // One transaction. d = WAIT-cycle index (0-based) carrying the completion
    // strobe; d >= TO means no strobe before the timeout.
    task automatic run_txn(input logic r0, input logic r1, input logic rw0, input logic rw1,
                           input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input int d, input bit drop);
        int          win;
        logic        rw;
        logic [15:0] c;
        logic [15:0] w;
        int          lat;
        int          exp_lat;
        bit          exp_to;
        logic [31:0] rdv;

        bus.req0 = r0;  bus.req1 = r1;
        bus.rw0  = rw0; bus.rw1  = rw1;
        bus.cmd0 = c0;  bus.cmd1 = c1;
        bus.wdat0 = w0; bus.wdat1 = w1;
        bus.vme_cmd_rd = 1'b1;
        // Strobe noise in IDLE/ISSUE must be ignored.
        bus.vme_dat_wr      = 1'($urandom);
        bus.vme_dat_reg_out = $urandom;

        win = (r0 && r1) ? ((last_gnt == 1) ? 0 : 1) : (r0 ? 0 : 1);
        rw  = (win == 1) ? rw1 : rw0;
        c   = (win == 1) ? c1  : c0;
        w   = (win == 1) ? w1  : w0;

        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.start) begin
                lat = i;
                break;
            end
        end
        check_eq("grant_latency", lat, 1);
        if (lat == 0) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            bus.vme_dat_wr = 1'b0;
            return;
        end
        check_eq("issue.ack0", bus.ack0, (win == 0));
        check_eq("issue.ack1", bus.ack1, (win == 1));
        check_eq("issue.cmd",  bus.vme_cmd_reg, exp_cmd(rw, c));
        check_eq("issue.dat",  bus.vme_dat_reg_in, rw ? 32'h0 : {16'h0000, w});
        check_eq("issue.busy", bus.busy, 1'b1);
        bus.vme_dat_wr      = 1'($urandom);
        bus.vme_dat_reg_out = $urandom;
        bus.vme_cmd_rd      = 1'($urandom);

        exp_to  = (d >= TO);
        exp_lat = exp_to ? TO + 1 : d + 2;
        lat     = 0;
        rdv     = '0;
        for (int i = 1; i <= TO + 4; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                lat = i;
                break;
            end
            if (i == 1) begin
                check_eq("wait.start", bus.start, 1'b0);
                check_eq("wait.ack",   {bus.ack0, bus.ack1}, 2'b00);
                check_eq("wait.cmd",   bus.vme_cmd_reg, exp_cmd(rw, c));
                check_eq("wait.busy",  bus.busy, 1'b1);
            end
            bus.vme_dat_wr      = (i == d + 1);
            bus.vme_dat_reg_out = $urandom;
            if (i == d + 1) rdv = bus.vme_dat_reg_out;
        end
        check_eq("done_latency", lat, exp_lat);
        if (lat != 0) begin
            if (!exp_to && rw) m_rdata[win] = rdv[15:0];
            check_eq("done.done0", bus.done0, (win == 0));
            check_eq("done.done1", bus.done1, (win == 1));
            check_eq("done.err0",  bus.err0, (exp_to && win == 0));
            check_eq("done.err1",  bus.err1, (exp_to && win == 1));
            check_eq("done.rdata0", bus.rdata0, m_rdata[0]);
            check_eq("done.rdata1", bus.rdata1, m_rdata[1]);
            check_eq("done.busy",  bus.busy, 1'b0);
            check_eq("done.start", bus.start, 1'b0);
            check_eq("done.cmd",   bus.vme_cmd_reg, MASK);
            check_eq("done.dat",   bus.vme_dat_reg_in, 32'h0);
        end
        bus.vme_dat_wr = 1'b0;
        if (drop) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        last_gnt = win;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        int dones;
        int r;

        m_rdata[0] = '0;
        m_rdata[1] = '0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.rw0  = 1'b0; bus.rw1  = 1'b0;
        bus.cmd0 = '0;   bus.cmd1 = '0;
        bus.wdat0 = '0;  bus.wdat1 = '0;
        bus.vme_cmd_rd = 1'b1;
        bus.vme_dat_wr = 1'b0;
        bus.vme_dat_reg_out = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Tie held for four transactions: grant order 0,1,0,1.
        for (int k = 0; k < 4; k++)
            run_txn(1'b1, 1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), k, (k == 3));
        @(negedge clk);

        // Read by requester 0.
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h4100, 16'h0, 16'h0, 16'h0, 1, 1'b1);
        check_eq("read0.rdata_cap", bus.rdata0, 16'h0000 | m_rdata[0]);
        // Write by requester 1.
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h7000, 16'h0, 16'h00FF, 2, 1'b1);
        // Timeout on a read, then completion on the timeout cycle.
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h4100, 16'h0, 16'h0, 16'h0, TO + 10, 1'b1);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h2222, 16'h0, 16'h0, TO - 1, 1'b1);

        for (int k = 0; k < 16; k++) begin
            r = $urandom_range(1, 3);
            run_txn(1'(r & 1), 1'(r >> 1), 1'($urandom), 1'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 6),
                    1'($urandom));
            if (bus.req0 == 1'b0 && bus.req1 == 1'b0)
                repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Engine not ready: request must not be issued.
        bus.vme_cmd_rd = 1'b0;
        bus.req0 = 1'b1;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.start) starts++;
        end
        check_eq("gate.starts", starts, 0);
        check_eq("gate.busy", bus.busy, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0ABC, 16'h0, 16'h5A5A, 16'h0, 0, 1'b1);

        // Reset in WAIT aborts without done.
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.rw0 = 1'b1; bus.cmd0 = 16'h1234;
        bus.vme_cmd_rd = 1'b1;
        @(negedge clk);
        check_eq("rstmid.start", bus.start, 1'b1);
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rstmid.busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        bus.vme_dat_wr = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        last_gnt = 1;
        #1;
        check_idle("rstmid.async");
        @(negedge clk);
        check_idle("rstmid.held");
        rst = 1'b0;
        bus.vme_dat_wr = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1 || bus.err0 || bus.err1) dones++;
        end
        check_eq("rstmid.no_done", dones, 0);
        check_idle("rstmid.after");

        // Pointer is back at 1: requester 0 wins the first tie.
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 16'h0101, 16'h0202, 16'h0, 16'h0, 3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
